// File: rtl/aes_key_expand_if.sv
// Key-schedule bus: cipher key load handshake, status flags and the
// registered round-key read port between aes_key_expand and its user.
interface aes_key_expand_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_ready;
    logic [3:0]   rk_sel;
    logic [127:0] rk_out;

    modport master (
        output key_in, key_valid, rk_sel,
        input  key_ready, busy, keys_ready, rk_out
    );

    modport slave (
        input  key_in, key_valid, rk_sel,
        output key_ready, busy, keys_ready, rk_out
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an
// NR+1 entry key file, read back through a registered port.
//
//  state  | meaning
//  IDLE   | no key loaded yet, accepting a cipher key
//  EXPAND | generating rk[cnt] from rk[cnt-1], one per cycle
//  DONE   | key file complete, a new key restarts expansion
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             reset,
    aes_key_expand_if.slave  kbus
);

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state;
    state_t       state_next;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic [127:0] rk [0:NR];

    logic         accepting;
    logic         load;
    logic         step;
    logic [127:0] prev_rk;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon_next;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: keys only accepted outside EXPAND
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: if (kbus.key_valid) state_next = EXPAND;
            EXPAND:     if (cnt == LAST)    state_next = DONE;
            default:                        state_next = IDLE;
        endcase
    end

    // Output decode; key_ready is forced low while reset is held
    always_comb begin
        accepting       = 1'b0;
        kbus.busy       = 1'b0;
        kbus.keys_ready = 1'b0;
        step            = 1'b0;
        unique case (state)
            IDLE:    accepting = 1'b1;
            EXPAND:  begin kbus.busy = 1'b1; step = 1'b1; end
            DONE:    begin accepting = 1'b1; kbus.keys_ready = 1'b1; end
            default: accepting = 1'b0;
        endcase
        kbus.key_ready = accepting & reset;
        load           = accepting & kbus.key_valid;
    end

    // One round of the key schedule from the previous round key
    always_comb begin
        prev_rk   = (cnt == 4'd0) ? 128'h0 : rk[cnt - 4'd1];
        {w0, w1, w2, w3} = prev_rk;
        t_word    = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]}
                    ^ {rcon, 24'h0};
        n0        = w0 ^ t_word;
        n1        = w1 ^ n0;
        n2        = w2 ^ n1;
        n3        = w3 ^ n2;
        rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end

    // Key file, round counter, rcon and registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= NR; i++) rk[i] <= 128'h0;
            rcon        <= 8'h01;
            cnt         <= 4'd0;
            kbus.rk_out <= 128'h0;
        end else begin
            if (load) begin
                rk[0] <= kbus.key_in;
                rcon  <= 8'h01;
                cnt   <= 4'd1;
            end else if (step) begin
                rk[cnt] <= {n0, n1, n2, n3};
                rcon    <= rcon_next;
                cnt     <= cnt + 4'd1;
            end
            kbus.rk_out <= (kbus.rk_sel <= LAST) ? rk[kbus.rk_sel] : 128'h0;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 and all-zero key schedules, ignored
// keys during expansion, mid-expansion reset, back-to-back reloads.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic reset;

    aes_key_expand_if kbus ();

    aes_key_expand #(.NR(10)) dut (
        .clk   (clk),
        .reset (reset),
        .kbus  (kbus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] sb_q [$];
    logic [127:0] fips_rk [11];
    logic [127:0] zero_rk [11];

    task automatic run_key(input logic [127:0] k, output int cyc);
        @(negedge clk);
        kbus.key_in    = k;
        kbus.key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kbus.key_valid = 1'b0;
        cyc = 0;
        while (!kbus.keys_ready && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset          = 1'b0;
        kbus.key_in    = '0;
        kbus.key_valid = 1'b0;
        kbus.rk_sel    = 4'd0;
        repeat (3) @(negedge clk);
        n_vec += 4;
        if (kbus.key_ready !== 1'b0) begin n_err++; $display("FAIL reset key_ready got %b want 0", kbus.key_ready); end
        if (kbus.busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b want 0", kbus.busy); end
        if (kbus.keys_ready !== 1'b0) begin n_err++; $display("FAIL reset keys_ready got %b want 0", kbus.keys_ready); end
        if (kbus.rk_out !== 128'h0) begin n_err++; $display("FAIL reset rk_out got %h want 0", kbus.rk_out); end
        reset = 1'b1;
        #1;
        n_vec++;
        if (kbus.key_ready !== 1'b1) begin n_err++; $display("FAIL idle key_ready got %b want 1", kbus.key_ready); end
    endtask

    task automatic test_sweep(input bit use_zero, input string tag);
        logic [127:0] exp;
        for (int s = 0; s <= 16; s++) begin
            @(negedge clk);
            if (s > 0) begin
                exp = sb_q.pop_front();
                n_vec++;
                if (kbus.rk_out !== exp) begin
                    n_err++;
                    $display("FAIL %s rk_out sel=%0d got %h want %h", tag, s - 1, kbus.rk_out, exp);
                end
            end
            if (s < 16) begin
                kbus.rk_sel = 4'(s);
                if (s <= 10) sb_q.push_back(use_zero ? zero_rk[s] : fips_rk[s]);
                else         sb_q.push_back(128'h0);
            end
        end
    endtask

    task automatic test_fips;
        logic [127:0] exp;
        @(negedge clk);
        kbus.rk_sel    = 4'd1;
        kbus.key_in    = fips_rk[0];
        kbus.key_valid = 1'b1;
        sb_q.push_back(128'h0);
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) kbus.key_valid = 1'b0;
            exp = sb_q.pop_front();
            n_vec += 4;
            if (kbus.rk_out !== exp) begin n_err++; $display("FAIL fips_rd1 edge+%0d got %h want %h", i, kbus.rk_out, exp); end
            if (kbus.keys_ready !== (i == 10)) begin n_err++; $display("FAIL fips_keys_ready edge+%0d got %b want %b", i, kbus.keys_ready, i == 10); end
            if (kbus.busy !== (i < 10)) begin n_err++; $display("FAIL fips_busy edge+%0d got %b want %b", i, kbus.busy, i < 10); end
            if (kbus.key_ready !== (i == 10)) begin n_err++; $display("FAIL fips_key_ready edge+%0d got %b want %b", i, kbus.key_ready, i == 10); end
            if (i < 10) sb_q.push_back((i == 0) ? 128'h0 : fips_rk[1]);
        end
        test_sweep(1'b0, "fips_sweep");
    endtask

    task automatic test_zero;
        int cyc;
        run_key(128'h0, cyc);
        n_vec++;
        if (cyc !== 10) begin n_err++; $display("FAIL zero_latency got %0d want 10", cyc); end
        test_sweep(1'b1, "zero_sweep");
    endtask

    task automatic test_ignore;
        int c;
        @(negedge clk);
        kbus.key_in    = fips_rk[0];
        kbus.key_valid = 1'b1;
        @(posedge clk);
        c = 0;
        forever begin
            @(negedge clk);
            if (c == 0) kbus.key_valid = 1'b0;
            if (c == 4) begin
                kbus.key_in    = 128'h0;
                kbus.key_valid = 1'b1;
                #1;
                n_vec += 2;
                if (kbus.key_ready !== 1'b0) begin n_err++; $display("FAIL ignore_key_ready got %b want 0", kbus.key_ready); end
                if (kbus.busy !== 1'b1) begin n_err++; $display("FAIL ignore_busy got %b want 1", kbus.busy); end
            end
            if (c == 5) kbus.key_valid = 1'b0;
            if (kbus.keys_ready || c >= 40) break;
            @(posedge clk);
            c++;
        end
        n_vec++;
        if (c !== 10) begin n_err++; $display("FAIL ignore_latency got %0d want 10", c); end
        test_sweep(1'b0, "ignore_sweep");
    endtask

    task automatic test_reset_mid;
        logic [127:0] exp;
        int cyc;
        @(negedge clk);
        kbus.rk_sel    = 4'd10;
        kbus.key_in    = fips_rk[0];
        kbus.key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kbus.key_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (kbus.rk_out !== fips_rk[10]) begin n_err++; $display("FAIL midrst_stale got %h want %h", kbus.rk_out, fips_rk[10]); end
        #2 reset = 1'b0;
        #1;
        n_vec += 4;
        if (kbus.key_ready !== 1'b0) begin n_err++; $display("FAIL midrst key_ready got %b want 0", kbus.key_ready); end
        if (kbus.busy !== 1'b0) begin n_err++; $display("FAIL midrst busy got %b want 0", kbus.busy); end
        if (kbus.keys_ready !== 1'b0) begin n_err++; $display("FAIL midrst keys_ready got %b want 0", kbus.keys_ready); end
        if (kbus.rk_out !== 128'h0) begin n_err++; $display("FAIL midrst rk_out got %h want 0", kbus.rk_out); end
        @(negedge clk);
        reset = 1'b1;
        sb_q.push_back(128'h0);
        @(negedge clk);
        exp = sb_q.pop_front();
        n_vec++;
        if (kbus.rk_out !== exp) begin n_err++; $display("FAIL midrst_cleared got %h want %h", kbus.rk_out, exp); end
        run_key(128'h0, cyc);
        n_vec++;
        if (cyc !== 10) begin n_err++; $display("FAIL midrst_latency got %0d want 10", cyc); end
        test_sweep(1'b1, "midrst_sweep");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        kbus.rk_sel    = 4'd10;
        kbus.key_in    = fips_rk[0];
        kbus.key_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= 21; i++) begin
            @(negedge clk);
            if (i == 0)  kbus.key_in    = 128'h0;
            if (i == 11) begin
                kbus.key_valid = 1'b0;
                n_vec++;
                if (kbus.rk_out !== fips_rk[10]) begin n_err++; $display("FAIL b2b_fips_rk10 got %h want %h", kbus.rk_out, fips_rk[10]); end
            end
            n_vec++;
            if (kbus.keys_ready !== (i == 10 || i == 21)) begin
                n_err++;
                $display("FAIL b2b_keys_ready edge+%0d got %b want %b", i, kbus.keys_ready, (i == 10 || i == 21));
            end
            @(posedge clk);
        end
        test_sweep(1'b1, "b2b_sweep");
    endtask

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_rk[0]  = 128'h00000000000000000000000000000000;
        zero_rk[1]  = 128'h62636363626363636263636362636363;
        zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        zero_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
        zero_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
        zero_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
        zero_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
        zero_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
        zero_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
        zero_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
        zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        test_reset();
        test_fips();
        test_zero();
        test_ignore();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
